// File: rtl/me_pe_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : me_pe_sched_ctrl
// Purpose  : Schedule controller for the ME PE array. After a current-block
//            preload it walks the search window column by column, scanning
//            each column either COARSE (sub-block pairs, two half-passes) or
//            FINE (four sub-block passes). Start/busy/done handshake, abort,
//            and a pe_ready stall that freezes the whole schedule.
// Ports    : clk, rst_n           - clock, async active-low reset
//            i_start, i_abort     - frame start (IDLE only), sync abort
//            i_pe_ready           - downstream accept; 0 freezes schedule
//            i_n_cols             - number of search columns (latched)
//            i_fine_lo/i_fine_hi  - inclusive FINE column range (latched)
//            o_busy, o_done       - not-IDLE flag, end-of-frame pulse
//            o_valid              - schedule step newly issued this cycle
//            o_curr_load_en, o_cb_sel, o_change_ref, o_ref_in_ctrl,
//            o_abs_ctrl           - PE array controls
//            o_col, o_row         - current search column / row
// Revision : 1.0 - initial release
// ============================================================================
module me_pe_sched_ctrl #(
  parameter int LOAD_CYC = 64,
  parameter int ROWS_C   = 38,
  parameter int PRE_C    = 8,
  parameter int ROWS_F   = 21,
  parameter int REF_F    = 4,
  parameter int COL_W    = 6,
  parameter int ROW_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pe_ready,
  input  logic [COL_W-1:0] i_n_cols,
  input  logic [COL_W-1:0] i_fine_lo,
  input  logic [COL_W-1:0] i_fine_hi,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_valid,
  output logic             o_curr_load_en,
  output logic             o_cb_sel,
  output logic             o_change_ref,
  output logic             o_ref_in_ctrl,
  output logic [1:0]       o_abs_ctrl,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row
);

  localparam int LD_W = $clog2(LOAD_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COARSE = 3'd2,
    S_FINE   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [LD_W-1:0]  r_ld_cnt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_half;
  logic [1:0]       r_sb;
  logic             r_valid;
  logic [COL_W-1:0] r_n_cols;
  logic [COL_W-1:0] r_fine_lo;
  logic [COL_W-1:0] r_fine_hi;

  logic [COL_W-1:0] w_col_nxt;
  logic             w_col_last;
  logic             w_fine0;
  logic             w_fine_nxt;
  logic             w_x;

  // An empty range (lo > hi) falls out naturally: no column satisfies both.
  function automatic logic in_fine(input logic [COL_W-1:0] c,
                                   input logic [COL_W-1:0] lo,
                                   input logic [COL_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  assign w_col_nxt  = r_col + COL_W'(1);
  assign w_col_last = (r_col == (r_n_cols - COL_W'(1)));
  assign w_fine0    = in_fine('0, r_fine_lo, r_fine_hi);
  assign w_fine_nxt = in_fine(w_col_nxt, r_fine_lo, r_fine_hi);

  // ---------------------------------------------------------------------------
  // State and counters. The flops always describe the step currently on the
  // outputs; on a ready edge they advance to the next step and r_valid marks
  // it as newly issued. On a stalled edge everything holds and r_valid drops,
  // so each step is presented with valid=1 exactly once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ld_cnt  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_half    <= 1'b0;
      r_sb      <= 2'd0;
      r_valid   <= 1'b0;
      r_n_cols  <= '0;
      r_fine_lo <= '0;
      r_fine_hi <= '0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_n_cols  <= i_n_cols;
            r_fine_lo <= i_fine_lo;
            r_fine_hi <= i_fine_hi;
            r_ld_cnt  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_half    <= 1'b0;
            r_sb      <= 2'd0;
            r_valid   <= 1'b1;
            r_state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_valid <= i_pe_ready;
          if (i_pe_ready) begin
            if (r_ld_cnt == LD_W'(LOAD_CYC - 1)) begin
              r_col   <= '0;
              r_row   <= '0;
              r_half  <= 1'b0;
              r_sb    <= 2'd0;
              r_state <= w_fine0 ? S_FINE : S_COARSE;
            end else begin
              r_ld_cnt <= r_ld_cnt + LD_W'(1);
            end
          end
        end

        S_COARSE: begin
          r_valid <= i_pe_ready;
          if (i_pe_ready) begin
            if (r_row == ROW_W'(ROWS_C - 1)) begin
              r_row <= '0;
              if (!r_half) begin
                r_half <= 1'b1;
              end else if (w_col_last) begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
              end else begin
                r_col   <= w_col_nxt;
                r_half  <= 1'b0;
                r_sb    <= 2'd0;
                r_state <= w_fine_nxt ? S_FINE : S_COARSE;
              end
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end

        S_FINE: begin
          r_valid <= i_pe_ready;
          if (i_pe_ready) begin
            if (r_row == ROW_W'(ROWS_F - 1)) begin
              r_row <= '0;
              if (r_sb != 2'd3) begin
                r_sb <= r_sb + 2'd1;
              end else if (w_col_last) begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
              end else begin
                r_col   <= w_col_nxt;
                r_half  <= 1'b0;
                r_sb    <= 2'd0;
                r_state <= w_fine_nxt ? S_FINE : S_COARSE;
              end
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end

        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // COARSE sub-block select bit: leading rows shift only, the middle band
  // alternates sub-blocks on odd/even rows, the trailing four rows use x=1.
  always_comb begin
    w_x = 1'b0;
    if (r_row < ROW_W'(PRE_C)) begin
      w_x = 1'b0;
    end else if (r_row < ROW_W'(ROWS_C - 4)) begin
      w_x = ~r_row[0];
    end else begin
      w_x = 1'b1;
    end
  end

  // Moore decode of state and counter flops only.
  always_comb begin
    o_busy         = (r_state != S_IDLE);
    o_done         = 1'b0;
    o_valid        = r_valid;
    o_curr_load_en = 1'b0;
    o_cb_sel       = 1'b0;
    o_change_ref   = 1'b0;
    o_ref_in_ctrl  = 1'b0;
    o_abs_ctrl     = 2'd0;
    o_col          = '0;
    o_row          = '0;
    case (r_state)
      S_IDLE: begin
        o_cb_sel = 1'b1;
      end
      S_LOAD: begin
        o_curr_load_en = 1'b1;
        o_cb_sel       = (r_ld_cnt < LD_W'(LOAD_CYC / 2));
        o_col          = r_col;
        o_row          = r_row;
      end
      S_COARSE: begin
        o_cb_sel      = ~r_half;
        o_ref_in_ctrl = 1'b1;
        o_abs_ctrl    = {r_half, w_x};
        // Middle band only changes reference on odd rows.
        o_change_ref  = ((r_row >= ROW_W'(PRE_C)) && (r_row < ROW_W'(ROWS_C - 4)))
                        ? r_row[0] : 1'b1;
        o_col         = r_col;
        o_row         = r_row;
      end
      S_FINE: begin
        o_change_ref  = 1'b1;
        o_abs_ctrl    = r_sb;
        o_ref_in_ctrl = (r_row < ROW_W'(REF_F));
        o_col         = r_col;
        o_row         = r_row;
      end
      S_DONE: begin
        o_done   = 1'b1;
        o_cb_sel = 1'b1;
      end
      default: begin
        o_cb_sel = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_me_pe_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_me_pe_sched_ctrl
// Purpose  : Directed self-checking bench for me_pe_sched_ctrl (default
//            parameters). Expected schedules are built from the documented
//            row/column pattern and compared step by step on valid cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_pe_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_pe_ready = 1'b1;
  logic [5:0] i_n_cols = '0;
  logic [5:0] i_fine_lo = '0;
  logic [5:0] i_fine_hi = '0;
  logic       o_busy, o_done, o_valid, o_curr_load_en, o_cb_sel;
  logic       o_change_ref, o_ref_in_ctrl;
  logic [1:0] o_abs_ctrl;
  logic [5:0] o_col;
  logic [6:0] o_row;

  int errors = 0;
  int checks = 0;

  logic [18:0] exp_q[$];
  logic [18:0] trace[0:2599];
  logic [18:0] obs_pk;

  me_pe_sched_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_pe_ready     (i_pe_ready),
    .i_n_cols       (i_n_cols),
    .i_fine_lo      (i_fine_lo),
    .i_fine_hi      (i_fine_hi),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_valid        (o_valid),
    .o_curr_load_en (o_curr_load_en),
    .o_cb_sel       (o_cb_sel),
    .o_change_ref   (o_change_ref),
    .o_ref_in_ctrl  (o_ref_in_ctrl),
    .o_abs_ctrl     (o_abs_ctrl),
    .o_col          (o_col),
    .o_row          (o_row)
  );

  always #5 clk = ~clk;

  assign obs_pk = {o_curr_load_en, o_cb_sel, o_change_ref, o_ref_in_ctrl,
                   o_abs_ctrl, o_col, o_row};

  function automatic logic [18:0] pk(input logic ld, input logic cb,
                                     input logic chg, input logic rf,
                                     input logic [1:0] ab, input int c,
                                     input int r);
    logic [5:0] c6;
    logic [6:0] r7;
    c6 = c[5:0];
    r7 = r[6:0];
    return {ld, cb, chg, rf, ab, c6, r7};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected valid-cycle sequence for one frame.
  task automatic build_exp(input int n, input int lo, input int hi);
    logic x, chg, h1;
    logic [1:0] s2;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pk(1'b1, i < 32, 1'b0, 1'b0, 2'd0, 0, 0));
    for (int c = 0; c < n; c++) begin
      if (c >= lo && c <= hi) begin
        for (int sb = 0; sb < 4; sb++) begin
          s2 = sb[1:0];
          for (int r = 0; r < 21; r++) exp_q.push_back(pk(1'b0, 1'b0, 1'b1, r < 4, s2, c, r));
        end
      end else begin
        for (int h = 0; h < 2; h++) begin
          h1 = h[0];
          for (int r = 0; r < 38; r++) begin
            if (r < 8)       begin x = 1'b0;        chg = 1'b1;      end
            else if (r < 34) begin x = (r % 2 == 0); chg = (r % 2 == 1); end
            else             begin x = 1'b1;        chg = 1'b1;      end
            exp_q.push_back(pk(1'b0, ~h1, chg, 1'b1, {h1, x}, c, r));
          end
        end
      end
    end
  endtask

  // Caller is positioned at the first negedge after the start edge (idx 0).
  task automatic run_frame(input int budget, input bit stall, input bit inj,
                           output int done_idx);
    done_idx = -1;
    for (int idx = 0; idx < budget; idx++) begin
      if (o_done) begin
        done_idx = idx;
        break;
      end
      if (o_valid) begin
        if (!stall && idx < 2600) trace[idx] = obs_pk;
        if (exp_q.size() == 0) check("trace_extra_step", 32'(exp_q.size()), 32'd1);
        else check("trace_step", 32'(obs_pk), 32'(exp_q.pop_front()));
      end
      i_pe_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && idx == 30) begin
        i_start = 1'b1; i_n_cols = 6'd5; i_fine_lo = 6'd0; i_fine_hi = 6'd31;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    i_pe_ready = 1'b1;
  endtask

  task automatic do_start(input int n, input int lo, input int hi);
    i_n_cols = 6'(n); i_fine_lo = 6'(lo); i_fine_hi = 6'(hi);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Checks around and after the done pulse; caller sits on the done cycle.
  task automatic check_done_tail(input string tag);
    int extra;
    check({tag, "_done_valid"}, o_valid, 1'b0);
    check({tag, "_done_busy"}, o_busy, 1'b1);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_busy_drop"}, o_busy, 1'b0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_done) extra++;
      @(negedge clk);
    end
    check({tag, "_single_done"}, extra, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit found;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cb_sel", o_cb_sel, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_pk", 32'(obs_pk), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0)));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", o_busy, 1'b0);

    // abort outranks start in IDLE
    i_start = 1'b1; i_abort = 1'b1; i_n_cols = 6'd1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_over_start", o_busy, 1'b0);

    // Default frame, no stalls
    build_exp(32, 8, 15);
    do_start(32, 8, 15);
    check("start_busy", o_busy, 1'b1);
    check("start_load_en", o_curr_load_en, 1'b1);
    run_frame(3000, 1'b0, 1'b0, d);
    // 64 load + 24*76 + 8*84 = 2560 valid cycles at idx 0..2559
    check("dflt_done_idx", d, 2560);
    check("ld_first", 32'(trace[0]),    32'(pk(1, 1, 0, 0, 2'd0, 0, 0)));
    check("ld_31",    32'(trace[31]),   32'(pk(1, 1, 0, 0, 2'd0, 0, 0)));
    check("ld_32",    32'(trace[32]),   32'(pk(1, 0, 0, 0, 2'd0, 0, 0)));
    check("c0_r0",    32'(trace[64]),   32'(pk(0, 1, 1, 1, 2'd0, 0, 0)));
    check("c0_r8",    32'(trace[72]),   32'(pk(0, 1, 0, 1, 2'd1, 0, 8)));
    check("c0_r9",    32'(trace[73]),   32'(pk(0, 1, 1, 1, 2'd0, 0, 9)));
    check("c0_r34",   32'(trace[98]),   32'(pk(0, 1, 1, 1, 2'd1, 0, 34)));
    check("c0_r37",   32'(trace[101]),  32'(pk(0, 1, 1, 1, 2'd1, 0, 37)));
    check("c0_h1_r0", 32'(trace[102]),  32'(pk(0, 0, 1, 1, 2'd2, 0, 0)));
    check("c0_h1_r8", 32'(trace[110]),  32'(pk(0, 0, 0, 1, 2'd3, 0, 8)));
    check("c1_r0",    32'(trace[140]),  32'(pk(0, 1, 1, 1, 2'd0, 1, 0)));
    check("f8_r0",    32'(trace[672]),  32'(pk(0, 0, 1, 1, 2'd0, 8, 0)));
    check("f8_r3",    32'(trace[675]),  32'(pk(0, 0, 1, 1, 2'd0, 8, 3)));
    check("f8_r4",    32'(trace[676]),  32'(pk(0, 0, 1, 0, 2'd0, 8, 4)));
    check("f8_sb1",   32'(trace[693]),  32'(pk(0, 0, 1, 1, 2'd1, 8, 0)));
    check("f8_sb3e",  32'(trace[755]),  32'(pk(0, 0, 1, 0, 2'd3, 8, 20)));
    check("f9_r0",    32'(trace[756]),  32'(pk(0, 0, 1, 1, 2'd0, 9, 0)));
    check("c16_r0",   32'(trace[1344]), 32'(pk(0, 1, 1, 1, 2'd0, 16, 0)));
    check("c31_last", 32'(trace[2559]), 32'(pk(0, 0, 1, 1, 2'd3, 31, 37)));
    if (d >= 0) check_done_tail("dflt");
    else check("dflt_done_seen", 32'(d), 32'd2560);

    // Same frame with random stalls: valid-qualified trace must not change
    build_exp(32, 8, 15);
    do_start(32, 8, 15);
    run_frame(9000, 1'b1, 1'b0, d);
    check("stall_done_seen", d >= 2560, 1'b1);
    if (d >= 0) check_done_tail("stall");

    // Abort mid-frame at COARSE column 5 row 20
    do_start(32, 8, 15);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (o_valid && o_col == 6'd5 && o_row == 7'd20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach", found, 1'b1);
    check("abort_pt_cb", o_cb_sel, 1'b1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", o_busy, 1'b0);
    check("abort_valid", o_valid, 1'b0);
    check("abort_done", o_done, 1'b0);
    check("abort_pk", 32'(obs_pk), 32'(pk(0, 1, 0, 0, 2'd0, 0, 0)));
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_done) found = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", found, 1'b0);

    // Restart: empty FINE range, one COARSE column; stray start ignored
    build_exp(1, 3, 2);
    do_start(1, 3, 2);
    check("restart_busy", o_busy, 1'b1);
    check("restart_pk", 32'(obs_pk), 32'(pk(1, 1, 0, 0, 2'd0, 0, 0)));
    run_frame(400, 1'b0, 1'b1, d);
    check("one_col_done_idx", d, 64 + 76);
    if (d >= 0) check_done_tail("onecol");

    // Asynchronous reset mid-frame
    do_start(32, 8, 15);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", o_busy, 1'b0);
    check("areset_pk", 32'(obs_pk), 32'(pk(0, 1, 0, 0, 2'd0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_idle", o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
